outagu: RTL
===========

# outagu

Output address generator and bit-plane writer for the MVU datapath: the write-side counterpart of the input/weight address generation that feeds the matrix-vector unit. It accepts one accumulated result vector per `acc_done` event, buffers it, and serialises it into bit-plane words. Each bit-plane word is written to the data memory at `obaseaddr` + a 3-level strided offset + the bit index, MSB first. It sits between the MVU accumulator/quantiser output and the data-memory write port.

## Interface
- `N`, 64: lanes per result vector (bits per bit-plane word)
- `BOUT`, 16: max output precision in bits; lane field width in `odata`
- `BPREC`, 6: bitwidth of precision field
- `BDBANKA`, 15: data memory address width
- `BWLENGTH`, 8: loop length width

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `clr`  in  1  synchronous clear; returns to IDLE and drops buffered data
- `start`  in  1  load configuration and arm (sampled in IDLE only)
- `oprecision`  in  BPREC  output precision P
- `obaseaddr`  in  BDBANKA  output base address
- `ostride0/1/2`  in  BDBANKA  offset jump when dim 0/1/2 is the highest dimension that increments
- `olength0/1/2`  in  BWLENGTH  iteration count minus one per dimension
- `valid`  in  1  result vector available (driven from `acc_done`)
- `odata`  in  N*BOUT  result vector; lane k occupies bits [k*BOUT +: BOUT]
- `ready`  out  1  vector accepted on `valid & ready`
- `wr_en`  out  1  memory write strobe
- `waddr`  out  BDBANKA  write address
- `wdata`  out  N  bit-plane word; bit k = bit `bit_sel` of lane k
- `bit_sel`  out  BPREC  bit plane being written
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle pulse after the final write of the job

## Operation
- Effective precision P = clamp(`oprecision`, 1, BOUT), latched with all other configuration on `start`. Later configuration-input changes are ignored until the next job.
- FSM states:
  - IDLE: `ready`=0. `start` latches the configuration, zeroes the offset and loop counters, and moves to RUN.
  - RUN: `ready`=1. An accepted vector loads the active buffer and moves to BURST.
  - BURST: emits P writes, one per cycle. Bit index b = 0..P-1; `waddr` = `obaseaddr` + offset + b; `bit_sel` = P-1-b; `wdata` = that plane of the active buffer.
- Buffering:
  - One pending buffer. In BURST, `ready` = pending empty.
  - A vector accepted in BURST goes to pending.
  - On the last write of a burst, if pending is full, it moves to active and the next burst starts the next cycle with no bubble. Otherwise the FSM returns to RUN.
- Loop advance on the last write of each burst, counters i0, i1, i2:
  - If i0 < `olength0`: i0++, offset += `ostride0`.
  - Else if i1 < `olength1`: i0=0, i1++, offset += `ostride1`.
  - Else if i2 < `olength2`: i0=i1=0, i2++, offset += `ostride2`.
  - Else: job complete. `done` pulses, FSM goes to IDLE, and any pending vector is discarded (protocol error: `ready` already low only if pending full).
- Arithmetic: all address sums are modulo 2^BDBANKA, wrap silently. Strides are unsigned.
- Total writes per job = (`olength0`+1)(`olength1`+1)(`olength2`+1)·P.

## Timing
- Reset values (async `rst_n` and sync `clr`): state IDLE; `wr_en`, `waddr`, `wdata`, `bit_sel`, `ready`, `busy`, `done` all 0; pending empty.
- All outputs are registered.
- Latency: a vector accepted at edge t produces its first `wr_en` in the cycle after t, and writes occupy P consecutive cycles.
- `done` is asserted in the cycle after the final `wr_en`. `busy` drops in the same cycle.
- `start` outside IDLE is ignored. `start` and `valid` in the same IDLE cycle: only `start` takes effect.
- `clr` or `rst_n` mid-burst: writes stop on the next edge, and no `done` is generated.

## Structure
- Shared package `mvu_pkg` holds:
  - FSM state encodings (IDLE/RUN/BURST)
  - default widths BPREC, BDBANKA, BWLENGTH, BOUT
- One natural sub-module, `outagu_loop`: the 3-level nested counter with the offset accumulator and a wrap/last flag, stepped once per burst end.
- Bit-plane extraction is an N-way mux on `bit_sel` in the top level.

## Test plan
- Single vector, P=4, lengths 0/0/0, base 0x100; lane 0=0xA, others 0. Required: writes at 0x100..0x103, `bit_sel` 3,2,1,0, `wdata[0]` 1,0,1,0; `done` in the cycle after 0x103.
- P=2, `olength0`=2, `olength1`=1, `ostride0`=2, `ostride1`=10, base 0. Required: burst start addresses 0,2,4,14,16,18; 12 writes total; exactly one `done`.
- Back-to-back: `valid` held high, P=3, 3 vectors. Required: 9 contiguous `wr_en` cycles; `ready` low while pending is full.
- `oprecision`=0 and `oprecision`=20 (with BOUT=16). Required: bursts of 1 and 16 writes respectively.
- Address wrap: base 0x7FFE, P=4. Required: addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Asserting `rst_n`=0 at write 2 of 4, then re-`start`. Required: outputs 0 immediately, no `done`; the new job begins at offset 0.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared MVU definitions: default datapath widths and the output address generator states.
package mvu_pkg;

    localparam int DEF_BPREC    = 6;
    localparam int DEF_BDBANKA  = 15;
    localparam int DEF_BWLENGTH = 8;
    localparam int DEF_BOUT     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } outagu_state_e;

endpackage

// File: rtl/outagu_loop.sv
// Three-level nested loop counter with a running address offset, stepped once per burst end.
module outagu_loop
    import mvu_pkg::*;
#(
    parameter int BDBANKA  = DEF_BDBANKA,
    parameter int BWLENGTH = DEF_BWLENGTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                init_i,
    input  logic                step_i,
    input  logic [BWLENGTH-1:0] length0_i,
    input  logic [BWLENGTH-1:0] length1_i,
    input  logic [BWLENGTH-1:0] length2_i,
    input  logic [BDBANKA-1:0]  stride0_i,
    input  logic [BDBANKA-1:0]  stride1_i,
    input  logic [BDBANKA-1:0]  stride2_i,
    output logic [BDBANKA-1:0]  offsetNext_o,
    output logic                last_o
);

    logic [BWLENGTH-1:0] i0_q, i0_d, i1_q, i1_d, i2_q, i2_d;
    logic [BDBANKA-1:0]  offset_q, offset_d;

    // The offset is cumulative: the stride of the highest advancing dimension is added, nothing is rewound.
    always_comb begin
        i0_d     = i0_q;
        i1_d     = i1_q;
        i2_d     = i2_q;
        offset_d = offset_q;
        if (init_i) begin
            i0_d     = '0;
            i1_d     = '0;
            i2_d     = '0;
            offset_d = '0;
        end else if (step_i) begin
            if (i0_q < length0_i) begin
                i0_d     = i0_q + 1'b1;
                offset_d = offset_q + stride0_i;
            end else if (i1_q < length1_i) begin
                i0_d     = '0;
                i1_d     = i1_q + 1'b1;
                offset_d = offset_q + stride1_i;
            end else if (i2_q < length2_i) begin
                i0_d     = '0;
                i1_d     = '0;
                i2_d     = i2_q + 1'b1;
                offset_d = offset_q + stride2_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0_q     <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            offset_q <= '0;
        end else if (clr) begin
            i0_q     <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            offset_q <= '0;
        end else begin
            i0_q     <= i0_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            offset_q <= offset_d;
        end
    end

    assign offsetNext_o = offset_d;
    assign last_o       = (i0_q == length0_i) && (i1_q == length1_i) && (i2_q == length2_i);

endmodule

// File: rtl/outagu.sv
// Output address generator: buffers MVU result vectors and writes them out as MSB-first bit planes.
module outagu
    import mvu_pkg::*;
#(
    parameter int N        = 64,
    parameter int BOUT     = DEF_BOUT,
    parameter int BPREC    = DEF_BPREC,
    parameter int BDBANKA  = DEF_BDBANKA,
    parameter int BWLENGTH = DEF_BWLENGTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                start,
    input  logic [BPREC-1:0]    oprecision,
    input  logic [BDBANKA-1:0]  obaseaddr,
    input  logic [BDBANKA-1:0]  ostride0,
    input  logic [BDBANKA-1:0]  ostride1,
    input  logic [BDBANKA-1:0]  ostride2,
    input  logic [BWLENGTH-1:0] olength0,
    input  logic [BWLENGTH-1:0] olength1,
    input  logic [BWLENGTH-1:0] olength2,
    input  logic                valid,
    input  logic [N*BOUT-1:0]   odata,
    output logic                ready,
    output logic                wr_en,
    output logic [BDBANKA-1:0]  waddr,
    output logic [N-1:0]        wdata,
    output logic [BPREC-1:0]    bit_sel,
    output logic                busy,
    output logic                done
);

    outagu_state_e       state_q, state_d;
    logic [BPREC-1:0]    prec_q, precClamped, bitIdx_q, bitIdx_d, bitSel_d;
    logic [BDBANKA-1:0]  base_q, stride0_q, stride1_q, stride2_q, offsetNext, waddr_d;
    logic [BWLENGTH-1:0] length0_q, length1_q, length2_q;
    logic [N*BOUT-1:0]   act_q, act_d, pend_q, pend_d;
    logic                pendFull_q, pendFull_d;
    logic                accept, lastWrite, loopLast, loopInit, loopStep, cfgLoad;
    logic                done_d, ready_d, wrEn_d;
    logic [N-1:0]        planeWord;
    logic [BOUT-1:0]     laneShift;

    outagu_loop #(.BDBANKA(BDBANKA), .BWLENGTH(BWLENGTH)) uLoop (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .init_i       (loopInit),
        .step_i       (loopStep),
        .length0_i    (length0_q),
        .length1_i    (length1_q),
        .length2_i    (length2_q),
        .stride0_i    (stride0_q),
        .stride1_i    (stride1_q),
        .stride2_i    (stride2_q),
        .offsetNext_o (offsetNext),
        .last_o       (loopLast)
    );

    always_comb begin
        precClamped = oprecision;
        if (oprecision == '0)
            precClamped = BPREC'(1);
        else if (oprecision > BPREC'(BOUT))
            precClamped = BPREC'(BOUT);
    end

    assign accept    = valid && ready;
    assign lastWrite = (bitIdx_q == prec_q - BPREC'(1));

    // A vector arriving on the final write of a burst goes straight to the active buffer so there is no bubble.
    always_comb begin
        state_d    = state_q;
        bitIdx_d   = bitIdx_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pendFull_d = pendFull_q;
        cfgLoad    = 1'b0;
        loopInit   = 1'b0;
        loopStep   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfgLoad  = 1'b1;
                    loopInit = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    act_d    = odata;
                    bitIdx_d = '0;
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    pend_d     = odata;
                    pendFull_d = 1'b1;
                end
                if (lastWrite) begin
                    loopStep = 1'b1;
                    if (loopLast) begin
                        state_d    = IDLE;
                        pendFull_d = 1'b0;
                        done_d     = 1'b1;
                    end else if (pendFull_q) begin
                        act_d      = pend_q;
                        pendFull_d = 1'b0;
                        bitIdx_d   = '0;
                    end else if (accept) begin
                        act_d      = odata;
                        pendFull_d = 1'b0;
                        bitIdx_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    bitIdx_d = bitIdx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bitSel_d = prec_q - BPREC'(1) - bitIdx_d;
    assign wrEn_d   = (state_d == BURST);
    assign ready_d  = (state_d == RUN) || ((state_d == BURST) && !pendFull_d);
    assign waddr_d  = base_q + offsetNext + BDBANKA'(bitIdx_d);

    always_comb begin
        planeWord = '0;
        laneShift = '0;
        for (int k = 0; k < N; k++) begin
            laneShift    = act_d[k*BOUT +: BOUT] >> bitSel_d;
            planeWord[k] = laneShift[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitIdx_q   <= '0;
            pendFull_q <= 1'b0;
            wr_en      <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            bit_sel    <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clr) begin
            state_q    <= IDLE;
            bitIdx_q   <= '0;
            pendFull_q <= 1'b0;
            wr_en      <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            bit_sel    <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitIdx_q   <= bitIdx_d;
            pendFull_q <= pendFull_d;
            wr_en      <= wrEn_d;
            waddr      <= wrEn_d ? waddr_d : '0;
            wdata      <= wrEn_d ? planeWord : '0;
            bit_sel    <= wrEn_d ? bitSel_d : '0;
            ready      <= ready_d;
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end

    // Vector buffers and job configuration carry no reset; they are only read once qualified by state.
    always_ff @(posedge clk) begin
        act_q  <= act_d;
        pend_q <= pend_d;
        if (cfgLoad) begin
            prec_q    <= precClamped;
            base_q    <= obaseaddr;
            stride0_q <= ostride0;
            stride1_q <= ostride1;
            stride2_q <= ostride2;
            length0_q <= olength0;
            length1_q <= olength1;
            length2_q <= olength2;
        end
    end

endmodule
